wasm_code_loader: RTL and testbench
===================================

# wasm_code_loader

Streaming boot loader that sits directly upstream of the instruction memory controller. It accepts a raw `.wasm` binary one byte per handshake and validates the 8-byte preamble. It skips every section except the code section (id 0x0A), then packs that section's payload into instruction-memory write windows. It releases the core with `o_load_done` once the last window is written. Until then the write port of the instruction memory is driven only by this block.

## Interface
Parameters:
- `WR_BYTES`, default 4: bytes per instruction-memory write window; `wr_data` width is `8*WR_BYTES`.
- `LOG_WR`, default 2: `$clog2(WR_BYTES)`; width of the shift field.
- `DEPTH_BYTES`, default 1024: instruction memory capacity in bytes.

Ports:
- `i_clk`, in, 1: the block's single clock.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_byte`, in, 8: stream byte.
- `i_byte_vld`, in, 1: stream byte valid.
- `i_byte_last`, in, 1: marks the final byte of the binary; qualified by `i_byte_vld`.
- `o_byte_rdy`, out, 1: loader accepts a byte when `i_byte_vld & o_byte_rdy`.
- `o_we`, out, 1: single-cycle write strobe to the instruction memory.
- `o_write_pointer_shift_minusone`, out, LOG_WR: number of valid bytes in `o_wr_data`, minus 1.
- `o_wr_data`, out, 8*WR_BYTES: packed code bytes; the earliest byte is in `[7:0]`.
- `o_load_done`, out, 1: sticky; code section fully written.
- `o_load_error`, out, 3: sticky error code.
  - 0: none.
  - 1: bad magic/version.
  - 2: LEB128 overflow.
  - 3: premature `i_byte_last`.
  - 4: code section larger than `DEPTH_BYTES`.
  - 5: stream ended without a code section.

## Operation
- **Reset:** all outputs are 0, except `o_byte_rdy`, which is 1. State is MAGIC; all counters are cleared.
- **MAGIC:** compare 8 accepted bytes against 00 61 73 6D 01 00 00 00. The first mismatch goes to ERR with code 1. After the 8th byte, go to SEC_ID.
- **SEC_ID:** latch the section id, then go to SEC_SIZE.
- **SEC_SIZE:** decode an unsigned LEB128 u32, low 7 bits first.
  - A continuation bit on the 5th byte, or any of bits [6:4] set in the 5th byte, is error code 2.
  - When the terminating byte arrives:
    - Id 0x0A with size 0: go to DONE (no writes).
    - Id 0x0A with size > `DEPTH_BYTES`: error code 4.
    - Id 0x0A, otherwise: go to CODE.
    - Any other id with size 0: go to SEC_ID.
    - Any other id, otherwise: go to SKIP.
- **SKIP:** count down the section size. At 0, return to SEC_ID.
- **CODE:** shift each byte into the pack register at lane `byte_cnt`.
  - A write is issued when `WR_BYTES` bytes are collected, or when the remaining size reaches 0.
  - The write carries `shift_minusone = collected-1`. Unused upper lanes are 0.
  - After the final write, go to DONE.
- **i_byte_last handling:**
  - In SEC_ID: error code 5.
  - In MAGIC, SEC_SIZE, SKIP, or CODE, on a byte that is not the section's final byte: error code 3.
  - On the final CODE byte: legal.
- **DONE and ERR:** `o_byte_rdy` stays 1 so that trailing bytes drain and are discarded. No further `o_we` is issued. Only reset exits these states.
- Errors take priority over writes. A byte that triggers an error produces no `o_we`, and any partial window is dropped.

## Timing
- The loader runs at one byte per cycle with no backpressure: `o_byte_rdy` is never deasserted.
- `o_we`, `o_wr_data`, and `o_write_pointer_shift_minusone` are registered. They assert on the cycle after the byte that completes a window is accepted, and are held for exactly 1 cycle.
- `o_load_done` rises the cycle after the final `o_we` pulse. For a zero-size code section, it rises the cycle after the size byte is accepted.
- `o_load_error` becomes valid the cycle after the offending byte is accepted.
- Reset asserted mid-load clears everything asynchronously. The next accepted byte is treated as magic byte 0.

## Structure
- Package `wasm_loader_pkg`:
  - Magic/version byte constants.
  - `SEC_CODE = 8'h0A`.
  - Error code enum.
  - State enum: MAGIC, SEC_ID, SEC_SIZE, SKIP, CODE, DONE, ERR.
- Sub-module `wasm_leb128_u32`: a byte-serial unsigned LEB128 decoder with outputs `value[31:0]`, `done`, and `overflow`, plus a `clear` input. The OperandStack/CtrlUnit LEB128 logic stays separate.

## Test plan
- **Minimal module:** preamble, then section 0x0A size 6, bytes 01..06 with `last` on 06. Required response:
  - `o_we` with data 0x04030201, shift 3.
  - Then `o_we` with data 0x00000605, shift 1.
  - `o_load_done` the following cycle.
- **Skip a section:** preamble, section 0x01 size 3 (3 bytes), then 0x0A size 4 (AA BB CC DD). Required response: exactly one `o_we`, with data 0xDDCCBBAA and shift 3.
- **Bad magic:** byte 2 = 0x74. Required response: `o_load_error` = 1 the next cycle, no `o_we`, and later bytes are accepted but ignored.
- **Multi-byte LEB128 and capacity:** code section size encoded as 80 08 (1024). Required response: 256 writes, then done. Size 81 08 (1025) gives error code 4.
- **Premature end and missing code section:**
  - `last` in the middle of the code payload gives error 3, and the partial window is not written.
  - `last` at a section boundary with no 0x0A section gives error 5.
- **Reset mid-load:** assert `i_rst_n` low during CODE. Required response: all outputs return to reset values; a fresh stream then loads correctly from address 0.

Source files
------------

// File: rtl/wasm_loader_pkg.sv
// Shared constants and types for the streaming .wasm code loader.
// Magic/version bytes are packed little-endian: byte i sits at [8*i +: 8].
package wasm_loader_pkg;

  localparam logic [31:0] WASM_MAGIC   = 32'h6D73_6100;
  localparam logic [31:0] WASM_VERSION = 32'h0000_0001;
  localparam logic [7:0]  SEC_CODE     = 8'h0A;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_MAGIC  = 3'd1,
    ERR_LEB    = 3'd2,
    ERR_EARLY  = 3'd3,
    ERR_SIZE   = 3'd4,
    ERR_NOCODE = 3'd5
  } err_e;

  typedef enum logic [2:0] {
    ST_MAGIC,
    ST_SEC_ID,
    ST_SEC_SIZE,
    ST_SKIP,
    ST_CODE,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic logic [7:0] magic_byte(input logic [2:0] i);
    logic [31:0] w;
    w = i[2] ? WASM_VERSION : WASM_MAGIC;
    return w[8*i[1:0] +: 8];
  endfunction

endpackage

// File: rtl/wasm_code_loader_leb.sv
// Byte-serial unsigned LEB128 u32 decoder; value/done/overflow are
// combinational on the current byte, state self-clears on completion.
module wasm_leb128_u32 (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_vld,
  input  logic [7:0]  i_byte,
  output logic [31:0] value,
  output logic        done,
  output logic        overflow
);

  logic [31:0] acc_q, acc_d;
  logic [2:0]  idx_q, idx_d;
  logic [5:0]  shamt;

  always_comb begin
    shamt    = {3'b000, idx_q} * 6'd7;
    value    = acc_q | (32'(i_byte[6:0]) << shamt);
    overflow = i_vld & (idx_q == 3'd4)
             & (i_byte[7] | (|i_byte[6:4]));
    done     = i_vld & ~i_byte[7] & ~overflow;
  end

  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    if (i_clear | done | overflow) begin
      acc_d = '0;
      idx_d = '0;
    end else if (i_vld) begin
      acc_d = value;
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/wasm_code_loader.sv
// Streaming .wasm boot loader: validates preamble, skips non-code
// sections and packs the code payload into imem write windows.
module wasm_code_loader
  import wasm_loader_pkg::*;
#(
  parameter int WR_BYTES    = 4,
  parameter int LOG_WR      = 2,
  parameter int DEPTH_BYTES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_vld,
  input  logic                  i_byte_last,
  output logic                  o_byte_rdy,
  output logic                  o_we,
  output logic [LOG_WR-1:0]     o_write_pointer_shift_minusone,
  output logic [8*WR_BYTES-1:0] o_wr_data,
  output logic                  o_load_done,
  output logic [2:0]            o_load_error
);

  localparam int DW = 8 * WR_BYTES;

  state_e            state_q, state_d;
  err_e              err_q, err_d;
  logic [2:0]        mcnt_q, mcnt_d;
  logic [7:0]        sec_id_q, sec_id_d;
  logic [31:0]       remain_q, remain_d;
  logic [LOG_WR-1:0] bcnt_q, bcnt_d;
  logic [LOG_WR-1:0] shift_q, shift_d;
  logic [DW-1:0]     pack_q, pack_d, pack_nxt;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              done_q, done_d;

  logic        acc;
  logic [31:0] leb_val;
  logic        leb_done, leb_ovf;
  logic        is_code, sz_zero, sz_big;
  logic        c_final, c_full;

  assign acc = i_byte_vld;

  wasm_leb128_u32 u_leb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (state_q != ST_SEC_SIZE),
    .i_vld    (acc & (state_q == ST_SEC_SIZE)),
    .i_byte   (i_byte),
    .value    (leb_val),
    .done     (leb_done),
    .overflow (leb_ovf)
  );

  always_comb begin
    is_code = sec_id_q == SEC_CODE;
    sz_zero = leb_val == 32'd0;
    sz_big  = leb_val > 32'(DEPTH_BYTES);
    c_final = remain_q == 32'd1;
    c_full  = bcnt_q == LOG_WR'(WR_BYTES - 1);
    pack_nxt = pack_q;
    pack_nxt[8*bcnt_q +: 8] = i_byte;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_MAGIC;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (acc) begin
      unique case (state_q)
        ST_MAGIC: begin
          if (i_byte != magic_byte(mcnt_q)) begin
            state_d = ST_ERR;
            err_d   = ERR_MAGIC;
          end else if (i_byte_last) begin
            state_d = ST_ERR;
            err_d   = ERR_EARLY;
          end else if (mcnt_q == 3'd7) begin
            state_d = ST_SEC_ID;
          end
        end
        ST_SEC_ID: begin
          if (i_byte_last) begin
            state_d = ST_ERR;
            err_d   = ERR_NOCODE;
          end else begin
            state_d = ST_SEC_SIZE;
          end
        end
        ST_SEC_SIZE: begin
          if (leb_ovf) begin
            state_d = ST_ERR;
            err_d   = ERR_LEB;
          end else if (leb_done) begin
            if (is_code & sz_zero) begin
              state_d = ST_DONE;
            end else if (is_code & sz_big) begin
              state_d = ST_ERR;
              err_d   = ERR_SIZE;
            end else if (i_byte_last) begin
              // size 0 ends the section: a stream ending here has no code
              state_d = ST_ERR;
              err_d   = sz_zero ? ERR_NOCODE : ERR_EARLY;
            end else if (sz_zero) begin
              state_d = ST_SEC_ID;
            end else begin
              state_d = is_code ? ST_CODE : ST_SKIP;
            end
          end else if (i_byte_last) begin
            state_d = ST_ERR;
            err_d   = ERR_EARLY;
          end
        end
        ST_SKIP: begin
          if (i_byte_last) begin
            state_d = ST_ERR;
            err_d   = c_final ? ERR_NOCODE : ERR_EARLY;
          end else if (c_final) begin
            state_d = ST_SEC_ID;
          end
        end
        ST_CODE: begin
          if (i_byte_last & ~c_final) begin
            state_d = ST_ERR;
            err_d   = ERR_EARLY;
          end else if (c_final) begin
            state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mcnt_d   = mcnt_q;
    sec_id_d = sec_id_q;
    remain_d = remain_q;
    bcnt_d   = bcnt_q;
    pack_d   = pack_q;
    we_d     = 1'b0;
    wdata_d  = '0;
    shift_d  = '0;
    done_d   = done_q | (state_q == ST_DONE);
    // an erroring byte must not write, so gate on the next state
    if (acc && state_d != ST_ERR) begin
      unique case (state_q)
        ST_MAGIC:  mcnt_d = mcnt_q + 3'd1;
        ST_SEC_ID: sec_id_d = i_byte;
        ST_SEC_SIZE: begin
          remain_d = leb_val;
          if (leb_done & is_code & sz_zero) done_d = 1'b1;
        end
        ST_SKIP:   remain_d = remain_q - 32'd1;
        ST_CODE: begin
          remain_d = remain_q - 32'd1;
          if (c_final | c_full) begin
            we_d    = 1'b1;
            wdata_d = pack_nxt;
            shift_d = bcnt_q;
            pack_d  = '0;
            bcnt_d  = '0;
          end else begin
            pack_d  = pack_nxt;
            bcnt_d  = bcnt_q + LOG_WR'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q    <= ERR_NONE;
      mcnt_q   <= '0;
      sec_id_q <= '0;
      remain_q <= '0;
      bcnt_q   <= '0;
      pack_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      shift_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      err_q    <= err_d;
      mcnt_q   <= mcnt_d;
      sec_id_q <= sec_id_d;
      remain_q <= remain_d;
      bcnt_q   <= bcnt_d;
      pack_q   <= pack_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
    end
  end

  assign o_byte_rdy                     = 1'b1;
  assign o_we                           = we_q;
  assign o_wr_data                      = wdata_q;
  assign o_write_pointer_shift_minusone = shift_q;
  assign o_load_done                    = done_q;
  assign o_load_error                   = err_q;

endmodule

// File: tb/tb_wasm_code_loader.sv
// Directed table-driven bench for wasm_code_loader with hand-written
// sequences for the full-capacity load and a reset during CODE.
module tb_wasm_code_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_byte = '0;
  logic        i_byte_vld = 1'b0;
  logic        i_byte_last = 1'b0;
  logic        o_byte_rdy;
  logic        o_we;
  logic [1:0]  o_shift;
  logic [31:0] o_wr_data;
  logic        o_load_done;
  logic [2:0]  o_load_error;

  wasm_code_loader dut (
    .i_clk                          (clk),
    .i_rst_n                        (rst_n),
    .i_byte                         (i_byte),
    .i_byte_vld                     (i_byte_vld),
    .i_byte_last                    (i_byte_last),
    .o_byte_rdy                     (o_byte_rdy),
    .o_we                           (o_we),
    .o_write_pointer_shift_minusone (o_shift),
    .o_wr_data                      (o_wr_data),
    .o_load_done                    (o_load_done),
    .o_load_error                   (o_load_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wq_data[$];
  logic [1:0]  wq_shift[$];
  int          we_last = -1;
  int          err_cyc = -1;
  int          done_cyc = -1;

  always @(negedge clk) begin
    if (o_we) begin
      wq_data.push_back(o_wr_data);
      wq_shift.push_back(o_shift);
      we_last = cyc;
    end
    if (o_load_error != 3'd0 && err_cyc < 0) err_cyc = cyc;
    if (o_load_done && done_cyc < 0) done_cyc = cyc;
  end

  int tests = 0;
  int fails = 0;
  int acc_cyc[2048];
  int nb = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic clear_mon();
    wq_data.delete();
    wq_shift.delete();
    we_last = -1;
    err_cyc = -1;
    done_cyc = -1;
    nb = 0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(nm, {o_we, o_load_done, o_load_error, o_byte_rdy, o_shift, o_wr_data},
        {1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 32'd0});
  endtask

  task automatic do_reset();
    i_byte_vld = 1'b0;
    i_byte_last = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] b, input bit l);
    i_byte = b;
    i_byte_vld = 1'b1;
    i_byte_last = l;
    @(posedge clk);
    #1;
    acc_cyc[nb] = cyc;
    nb++;
  endtask

  task automatic idle(input int n);
    i_byte_vld = 1'b0;
    i_byte_last = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [63:0] pre;
    logic [127:0] pay;
    int          len;
    int          last_i;
    int          n_we;
    logic [31:0] d0;
    logic [1:0]  s0;
    logic [31:0] d1;
    logic [1:0]  s1;
    logic [2:0]  err;
    int          err_at;
    logic        done;
    int          done_at;
  } vec_t;

  localparam logic [63:0] PRE = 64'h0061736D_01000000;
  localparam logic [63:0] BAD = 64'h0061746D_01000000;

  vec_t vt[10];

  task automatic run(input int k, input bit no_rst);
    vec_t v;
    v = vt[k];
    if (!no_rst) do_reset();
    clear_mon();
    for (int i = 0; i < 8; i++) push(v.pre[8*(7-i) +: 8], 1'b0);
    for (int i = 0; i < v.len; i++)
      push(v.pay[8*(v.len-1-i) +: 8], i == v.last_i);
    idle(6);
    chk({v.name, ".n_we"}, wq_data.size(), v.n_we);
    if (v.n_we >= 1) begin
      chk({v.name, ".d0"}, wq_data[0], v.d0);
      chk({v.name, ".s0"}, wq_shift[0], v.s0);
    end
    if (v.n_we >= 2) begin
      chk({v.name, ".d1"}, wq_data[1], v.d1);
      chk({v.name, ".s1"}, wq_shift[1], v.s1);
    end
    chk({v.name, ".err"}, o_load_error, v.err);
    if (v.err_at >= 0)
      chk({v.name, ".err_cyc"}, err_cyc, acc_cyc[v.err_at]);
    chk({v.name, ".done"}, o_load_done, v.done);
    if (v.done) begin
      if (v.n_we > 0) chk({v.name, ".done_cyc"}, done_cyc, we_last + 1);
      else chk({v.name, ".done_cyc"}, done_cyc, acc_cyc[v.done_at]);
    end
    chk({v.name, ".rdy"}, o_byte_rdy, 1'b1);
  endtask

  initial begin
    vt[0] = '{"minimal", PRE, 128'h0A06_0102_0304_0506, 8, 7,
              2, 32'h04030201, 2'd3, 32'h00000605, 2'd1, 3'd0, -1, 1'b1, -1};
    vt[1] = '{"skip", PRE, 128'h0103_112233_0A04_AABBCCDD, 11, 10,
              1, 32'hDDCCBBAA, 2'd3, 32'h0, 2'd0, 3'd0, -1, 1'b1, -1};
    vt[2] = '{"bad_magic", BAD, 128'h0A01_55, 3, 2,
              0, 32'h0, 2'd0, 32'h0, 2'd0, 3'd1, 2, 1'b0, -1};
    vt[3] = '{"premature", PRE, 128'h0A06_010203, 5, 4,
              0, 32'h0, 2'd0, 32'h0, 2'd0, 3'd3, 12, 1'b0, -1};
    vt[4] = '{"no_code", PRE, 128'h0101_77_05, 4, 3,
              0, 32'h0, 2'd0, 32'h0, 2'd0, 3'd5, 11, 1'b0, -1};
    vt[5] = '{"zero_code", PRE, 128'h0A00, 2, 1,
              0, 32'h0, 2'd0, 32'h0, 2'd0, 3'd0, -1, 1'b1, 9};
    vt[6] = '{"leb_ovf", PRE, 128'h0A_80808080_10, 6, 5,
              0, 32'h0, 2'd0, 32'h0, 2'd0, 3'd2, 13, 1'b0, -1};
    vt[7] = '{"size_1025", PRE, 128'h0A_8108, 3, -1,
              0, 32'h0, 2'd0, 32'h0, 2'd0, 3'd4, 10, 1'b0, -1};
    vt[8] = '{"three_lane", PRE, 128'h0A03_010203, 5, 4,
              1, 32'h00030201, 2'd2, 32'h0, 2'd0, 3'd0, -1, 1'b1, -1};
    vt[9] = '{"empty_sec", PRE, 128'h0000_0A01_9C, 5, 4,
              1, 32'h0000009C, 2'd0, 32'h0, 2'd0, 3'd0, -1, 1'b1, -1};

    for (int k = 0; k < 10; k++) run(k, 1'b0);

    // full-capacity load: 1024 bytes -> 256 windows
    do_reset();
    clear_mon();
    for (int i = 0; i < 8; i++) push(PRE[8*(7-i) +: 8], 1'b0);
    push(8'h0A, 1'b0);
    push(8'h80, 1'b0);
    push(8'h08, 1'b0);
    for (int i = 0; i < 1024; i++) push(i[7:0], i == 1023);
    idle(6);
    chk("big.n_we", wq_data.size(), 256);
    begin
      int nbad;
      logic [31:0] e;
      nbad = 0;
      for (int w = 0; w < wq_data.size(); w++) begin
        e = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
        if (wq_data[w] !== e || wq_shift[w] !== 2'd3) nbad++;
      end
      chk("big.bad_windows", nbad, 0);
    end
    chk("big.err", o_load_error, 3'd0);
    chk("big.done", o_load_done, 1'b1);
    chk("big.done_cyc", done_cyc, we_last + 1);

    // reset asserted while a write strobe is live in CODE
    do_reset();
    clear_mon();
    for (int i = 0; i < 8; i++) push(PRE[8*(7-i) +: 8], 1'b0);
    push(8'h0A, 1'b0);
    push(8'h06, 1'b0);
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    push(8'h04, 1'b0);
    chk("mid.we_live", o_we, 1'b1);
    i_byte_vld = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_reset_vals("mid.reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
